// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the demux1_4 round-robin scheduler.
// Provides the requester count, select width, FSM state type and a one-hot decoder.
package demux_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] one;
    one = NUM_REQ'(1);
    return one << sel;
  endfunction

endpackage

// File: rtl/demux1_4_rr_sched_rr_pick4.sv
// Combinational rotating-priority picker: returns the first set request bit
// starting at ptr and wrapping modulo 4.
module rr_pick4
  import demux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               valid
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux1_4_rr_sched.sv
// Round-robin scheduler driving a demux1_4 select/enable pair with bounded
// bursts and a mandatory idle cycle between grants.
module demux1_4_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [SEL_W-1:0]   sel_n;
  logic               en_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               release_now;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Drop the grant when the owner lets go, or when its burst is spent and
  // someone else is waiting. Both causes collapse into one release.
  assign release_now = !req[sel] ||
                       ((hold_cnt == HOLD_MAX) && ((req & ~gnt) != '0));

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    sel_n      = sel;
    en_n       = en;
    gnt_n      = gnt;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n    = GRANT;
          sel_n      = pick_idx;
          en_n       = 1'b1;
          gnt_n      = onehot4(pick_idx);
          hold_cnt_n = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_n    = IDLE;
          en_n       = 1'b0;
          gnt_n      = '0;
          ptr_n      = sel + SEL_W'(1);
          hold_cnt_n = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n    = IDLE;
        en_n       = 1'b0;
        gnt_n      = '0;
        hold_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      en       <= 1'b0;
      gnt      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      en       <= en_n;
      gnt      <= gnt_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: doc/demux1_4_rr_sched.md
Name: demux1_4_rr_sched

Overview:
- Round-robin scheduler that shares one demux1_4 output path among 4 requesters.
- Drives the demux select (a) and enable (e) from registered state. Grants one requester at a time for a bounded burst.
- Inserts a one-cycle dead gap between grants so the demux outputs never switch directly from one line to another.
- Sits directly in front of demux1_4; its sel/en outputs connect to the demux a/e ports.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles while another requester waits. Legal range 1..15.
- CNT_W, 4: width of the hold counter. Must hold the value MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  per-requester request; level, held while the requester wants the path
- sel  out  2  demux select, drives demux1_4 a
- en  out  1  demux enable, drives demux1_4 e
- gnt  out  4  one-hot grant; equals the demux output pattern
- busy  out  1  high while in GRANT

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n=0 without waiting for clk:
  - state=IDLE, sel=2'b00, en=0, gnt=4'b0000, busy=0
  - ptr=2'b00, hold_cnt=0
- All outputs are registered; no combinational path from req to any output.
- Priority pointer ptr: search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. Wraps 3->0.
- State IDLE:
  - If req != 0 at the clock edge, pick idx = first set bit in search order.
  - Next state GRANT; sel=idx, en=1, gnt=1<<idx, busy=1, hold_cnt=1.
  - Grant latency is 1 cycle: req sampled at edge N, gnt valid after edge N.
  - If req == 0, remain in IDLE with outputs idle.
- State GRANT, evaluated every edge:
  - Release if req[sel]==0.
  - Release if hold_cnt==MAX_HOLD and (req & ~gnt) != 0 (preemption).
  - If hold_cnt==MAX_HOLD and no other request is pending, stay in GRANT; hold_cnt saturates at MAX_HOLD.
  - Otherwise hold_cnt increments.
- Release:
  - Next state IDLE; en=0, gnt=0, busy=0.
  - sel keeps its last value.
  - ptr = sel+1 mod 4, so the released requester becomes lowest priority.
  - hold_cnt=0.
- Gap: every release produces at least one full cycle with en=0 before the next grant, because IDLE arbitrates only at the following edge.
- Simultaneous req drop and hold expiry in the same cycle: a single release; ptr is updated once.
- A requester that drops and re-raises req during the gap cycle is arbitrated normally against the others.
- MAX_HOLD=1: at most one cycle per grant while others wait; still gap-separated.
- Reset during GRANT: en and gnt drop asynchronously. After rst_n deasserts, the first grant uses ptr=0.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt == (en ? 1<<sel : 0).
  - busy == en.

Decomposition:
- Package demux_sched_pkg:
  - NUM_REQ=4, SEL_W=2
  - state typedef {IDLE, GRANT}
  - function onehot4(sel)
- One sub-module rr_pick4: combinational priority picker.
  - Inputs req[3:0], ptr[1:0].
  - Outputs idx[1:0], valid.
  - Instantiated once. The FSM, counter and pointer stay in the top.

Test Plan:
- Async reset: assert rst_n=0 mid-grant (gnt=0100), between clock edges -> en=0, gnt=0000, sel=00 immediately. After release with req=0000 -> outputs stay idle.
- Single request: req=0100 from reset, held 3 cycles then dropped -> after edge 1: sel=10, en=1, gnt=0100. En stays 1 for 3 cycles, drops on the edge after req falls. Internal ptr=11.
- Full contention, MAX_HOLD=4: req=1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 cycles, followed by 1 idle cycle (period 5).
- Wrap-around: after granting 0100 and releasing (ptr=3), apply req=1001 -> grant 1000 first, then after the gap 0001.
- Solo saturation: req=0010 alone for 20 cycles -> gnt=0010 continuously with no gap. Then set req[0]=1 -> 0010 released at the next edge, one idle cycle, then gnt=0001.
- Demux coherence: with demux1_4 instantiated on sel/en -> demux c == gnt on every cycle of all scenarios above, checked by assertion.
